// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcodes and sequencer states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam int INSTR_W = 12;

  localparam logic [2:0] OPC_LOAD   = 3'b000;
  localparam logic [2:0] OPC_STORE  = 3'b001;
  localparam logic [2:0] OPC_ADD    = 3'b010;
  localparam logic [2:0] OPC_SUBI   = 3'b101;
  localparam logic [2:0] OPC_BRANCH = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    UPDATE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/prog_sequencer_btn_edge.sv
// Button conditioner: 2-flop synchronizer followed by a registered rising-edge detector.
// Latency: one-cycle pulse three clocks after the raw input rises.
// Backpressure: none; the pulse is produced regardless of consumer state.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      sync2_d <= sync2;
      pulse   <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: owns pc, instruction register, mode and exec strobe; PROG_SEQUENCER_AUTO_RUN_EN adds auto-run.
// Latency: external step = pulse -> EXEC -> IDLE; internal step = FETCH (until imem_valid) -> EXEC -> UPDATE -> IDLE.
// Backpressure: imem_req held until imem_valid; button pulses arriving while busy are dropped.
module prog_sequencer #(
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int PC_W    = 4
`ifdef PROG_SEQUENCER_AUTO_RUN_EN
  ,
  parameter int RUN_DIV = 25_000_000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               left_button,
  input  logic               right_button,
  input  logic [INSTR_W-1:0] ext_instruction,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               EQ,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instruction,
  output logic               is_external,
  output logic               exec_en,
  output logic               busy
`ifdef PROG_SEQUENCER_AUTO_RUN_EN
  ,
  output logic               running
`endif
);

  import cpu_pkg::*;

  seq_state_t state;
  seq_state_t state_nxt;

  logic            left_pulse;
  logic            right_pulse;
  logic            left_cmd;
  logic            idle;
  logic            start_ext;
  logic            start_fetch;
  logic            eq_q;
  logic            br_taken;
  logic [PC_W-1:0] pc_nxt;

  btn_edge u_left_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (left_button),
    .pulse (left_pulse)
  );

  btn_edge u_right_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (right_button),
    .pulse (right_pulse)
  );

  // Simultaneous presses: the mode toggle wins, the step is dropped.
  assign idle      = (state == IDLE);
  assign left_cmd  = idle & left_pulse & ~right_pulse;
  assign start_ext = left_cmd & is_external;

`ifdef PROG_SEQUENCER_AUTO_RUN_EN
  localparam int CNT_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  logic             run_q;
  logic [CNT_W-1:0] run_cnt;
  logic             run_tick;

  assign run_tick    = run_q & idle & (run_cnt == CNT_W'(RUN_DIV - 1));
  assign start_fetch = run_tick & ~right_pulse;
  assign running     = run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else if (idle && right_pulse) begin
      run_q <= 1'b0;
    end else if (left_cmd && !is_external) begin
      run_q <= ~run_q;
    end
  end

  // Counts only while idle and running; holds through a step, restarts after terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (!run_q || run_tick) begin
      run_cnt <= '0;
    end else if (idle) begin
      run_cnt <= run_cnt + CNT_W'(1);
    end
  end
`else
  assign start_fetch = left_cmd & ~is_external;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ext) begin
          state_nxt = EXEC;
        end else if (start_fetch) begin
          state_nxt = FETCH;
        end
      end
      FETCH:   if (imem_valid) state_nxt = EXEC;
      EXEC:    state_nxt = is_external ? IDLE : UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state == FETCH);
    exec_en  = (state == EXEC);
    busy     = (state != IDLE);
  end

  assign imem_addr = pc;

  // Offset is zero-extended; the sum wraps modulo 2^PC_W.
  assign br_taken = (instruction[11:9] == OPC_BRANCH) & eq_q;
  assign pc_nxt   = pc + PC_W'(1) + (br_taken ? PC_W'(instruction[8:6]) : PC_W'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_external <= 1'b1;
      pc          <= '0;
      instruction <= '0;
      eq_q        <= 1'b0;
    end else begin
      if (idle && right_pulse) begin
        is_external <= ~is_external;
      end
      if (start_ext) begin
        instruction <= ext_instruction;
      end else if (state == FETCH && imem_valid) begin
        instruction <= imem_rdata;
      end
      if (state == EXEC) begin
        eq_q <= EQ;
      end
      if (state == UPDATE) begin
        pc <= pc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: directed steps push expectations, a monitor checks each exec strobe.
`timescale 1ns/1ps
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        left_button = 1'b0;
  logic        right_button = 1'b0;
  logic [11:0] ext_instruction = '0;
  logic [11:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        EQ = 1'b0;
  logic        imem_req;
  logic [3:0]  imem_addr;
  logic [3:0]  pc;
  logic [11:0] instruction;
  logic        is_external;
  logic        exec_en;
  logic        busy;

  prog_sequencer #(.INSTR_W(12), .PC_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .left_button     (left_button),
    .right_button    (right_button),
    .ext_instruction (ext_instruction),
    .imem_rdata      (imem_rdata),
    .imem_valid      (imem_valid),
    .EQ              (EQ),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .pc              (pc),
    .instruction     (instruction),
    .is_external     (is_external),
    .exec_en         (exec_en),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] instr;
    logic        ext;
    logic [3:0]  pc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int exec_cnt = 0;
  int pushes = 0;

  int          mem_wait = 0;
  logic [11:0] mem_data = '0;
  int          wcnt = 0;
  int          req_cycles = 0;
  int          addr_bad = 0;
  logic [3:0]  exp_addr = '0;
  bit          late_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Memory model: answers an outstanding request after mem_wait idle cycles.
  always @(negedge clk) begin
    if (late_valid) begin
      imem_valid = 1'b1;
      imem_rdata = 12'hFFF;
    end else if (imem_req === 1'b1) begin
      req_cycles++;
      if (imem_addr !== exp_addr) addr_bad++;
      if (wcnt >= mem_wait) begin
        imem_valid = 1'b1;
        imem_rdata = mem_data;
      end else begin
        imem_valid = 1'b0;
        wcnt++;
      end
    end else begin
      imem_valid = 1'b0;
      wcnt = 0;
    end
  end

  exp_t       cur;
  bit         pc_pend = 1'b0;
  bit         exec_prev = 1'b0;
  logic [3:0] pend_pc = '0;

  always @(negedge clk) begin
    if (exec_prev) check("exec_width", exec_en, 0);
    exec_prev = (exec_en === 1'b1);
    if (pc_pend && busy === 1'b0) begin
      check("pc_after_step", pc, pend_pc);
      pc_pend = 1'b0;
    end
    if (exec_en === 1'b1) begin
      exec_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_exec: exec_en seen with instruction=%0h, required no exec", instruction);
      end else begin
        cur = exp_q.pop_front();
        check("exec_instruction", instruction, cur.instr);
        check("exec_is_external", is_external, cur.ext);
        pend_pc = cur.pc;
        pc_pend = 1'b1;
      end
    end
  end

  task automatic press(input bit l, input bit r);
    @(negedge clk);
    left_button  = l;
    right_button = r;
    repeat (3) @(negedge clk);
    left_button  = 1'b0;
    right_button = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic ext_step(input logic [11:0] ins, input logic [3:0] pc_now);
    ext_instruction = ins;
    exp_q.push_back('{instr: ins, ext: 1'b1, pc: pc_now});
    pushes++;
    press(1'b1, 1'b0);
    wait_idle("ext_step");
  endtask

  task automatic int_step(input string name, input logic [11:0] data, input int wait_n,
                          input bit eq, input logic [3:0] pc_before, input logic [3:0] pc_after);
    mem_data   = data;
    mem_wait   = wait_n;
    EQ         = eq;
    exp_addr   = pc_before;
    req_cycles = 0;
    addr_bad   = 0;
    exp_q.push_back('{instr: data, ext: 1'b0, pc: pc_after});
    pushes++;
    press(1'b1, 1'b0);
    wait_idle(name);
    @(negedge clk);
    check({name, "_req_cycles"}, req_cycles, wait_n + 1);
    check({name, "_imem_addr_errs"}, addr_bad, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exec_before;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_instruction", instruction, 0);
    check("rst_is_external", is_external, 1);
    check("rst_imem_req", imem_req, 0);
    check("rst_exec_en", exec_en, 0);
    check("rst_busy", busy, 0);

    ext_step(12'h0A5, 4'd0);
    check("ext_mode_kept", is_external, 1);

    press(1'b0, 1'b1);
    check("right_to_internal", is_external, 0);

    int_step("fetch_wait2", 12'h213, 2, 1'b0, 4'd0, 4'd1);
    int_step("step_1_2", 12'h400, 0, 1'b0, 4'd1, 4'd2);
    int_step("step_2_3", 12'h400, 1, 1'b0, 4'd2, 4'd3);
    int_step("branch_taken", 12'hE80, 0, 1'b1, 4'd3, 4'd6);

    do_reset();
    check("rst2_pc", pc, 0);
    press(1'b0, 1'b1);
    int_step("step_0_1", 12'h400, 0, 1'b0, 4'd0, 4'd1);
    int_step("step_1_2b", 12'h400, 0, 1'b0, 4'd1, 4'd2);
    int_step("step_2_3b", 12'h400, 0, 1'b0, 4'd2, 4'd3);
    int_step("branch_not_taken", 12'hE80, 0, 1'b0, 4'd3, 4'd4);
    int_step("branch_off7", 12'hFC0, 0, 1'b1, 4'd4, 4'd12);
    int_step("branch_to_15", 12'hE80, 1, 1'b1, 4'd12, 4'd15);
    int_step("wrap_15_0", 12'h400, 0, 1'b0, 4'd15, 4'd0);
    int_step("branch_0_8", 12'hFC0, 0, 1'b1, 4'd0, 4'd8);
    int_step("branch_8_14", 12'hF40, 0, 1'b1, 4'd8, 4'd14);
    int_step("branch_wrap_14_6", 12'hFC0, 0, 1'b1, 4'd14, 4'd6);

    press(1'b0, 1'b1);
    check("right_to_external", is_external, 1);
    exec_before = exec_cnt;
    press(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("both_toggle_mode", is_external, 0);
    check("both_no_exec", exec_cnt - exec_before, 0);

    // Second left press lands while the first step is still fetching.
    mem_data   = 12'h400;
    mem_wait   = 12;
    EQ         = 1'b0;
    exp_addr   = 4'd6;
    exec_before = exec_cnt;
    exp_q.push_back('{instr: 12'h400, ext: 1'b0, pc: 4'd7});
    pushes++;
    press(1'b1, 1'b0);
    check("in_fetch_before_2nd_press", imem_req, 1);
    press(1'b1, 1'b0);
    wait_idle("press_in_fetch");
    repeat (4) @(negedge clk);
    check("press_in_fetch_single_exec", exec_cnt - exec_before, 1);
    check("press_in_fetch_pc", pc, 7);

    mem_wait   = 1000;
    exp_addr   = 4'd7;
    exec_before = exec_cnt;
    press(1'b1, 1'b0);
    check("fetch_pending_req", imem_req, 1);
    rst_n = 1'b0;
    #1;
    check("midfetch_rst_imem_req", imem_req, 0);
    check("midfetch_rst_exec_en", exec_en, 0);
    check("midfetch_rst_pc", pc, 0);
    check("midfetch_rst_is_external", is_external, 1);
    check("midfetch_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_wait = 0;
    late_valid = 1'b1;
    repeat (3) @(negedge clk);
    late_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("late_valid_busy", busy, 0);
    check("late_valid_pc", pc, 0);
    check("late_valid_instruction", instruction, 0);
    check("late_valid_no_exec", exec_cnt - exec_before, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    check("exec_total", exec_cnt, pushes);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
